// File: rtl/simproc_mem_host.sv
// simproc_mem_host: memory responder and run/halt host for the simproc core.
// Owns a 256x8 synchronous RAM (read-first, one-cycle read latency), takes a
// program image over a valid/ready byte loader, then runs the core and counts
// cycles until it halts.
// Optional feature macro: SIMPROC_MEM_WP_EN (write-protect addresses below
// WP_LIMIT against core writes during RUN; reports via sticky wp_err).
module simproc_mem_host #(
    parameter int         CYC_W    = 16,
    parameter logic [7:0] WP_LIMIT = 8'h80
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       mem_addr,
    input  logic [7:0]       mem_din,
    input  logic             mem_we,
    output logic [7:0]       mem_dout,
    output logic             run,
    input  logic             halt,
    input  logic             start,
    input  logic             ld_valid,
    input  logic [7:0]       ld_data,
    input  logic             ld_last,
    output logic             ld_ready,
    output logic             done,
    output logic [CYC_W-1:0] cycle_count,
    output logic             wp_err
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t     state, state_nxt;
    logic [7:0] ram [0:255];
    logic [7:0] ld_ptr;
    logic       armed;
    logic       start_load;
    logic       halt_seen;
    logic       wp_hit;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;

    // A load may only begin from an idle or finished machine
    assign start_load = start && ((state == IDLE) || (state == DONE));
    // Halt only counts once a 0 has been observed in this run
    assign halt_seen  = (state == RUN) && armed && halt;

`ifdef SIMPROC_MEM_WP_EN
    assign wp_hit = (state == RUN) && mem_we && (mem_addr < WP_LIMIT);

    // Sticky protected-write flag, cleared when a new load begins
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wp_err <= 1'b0;
        else if (start_load)
            wp_err <= 1'b0;
        else if (wp_hit)
            wp_err <= 1'b1;
    end
`else
    logic unused_wp_limit;
    assign unused_wp_limit = ^WP_LIMIT;
    assign wp_hit          = 1'b0;
    assign wp_err          = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nxt = state;
        run       = 1'b0;
        ld_ready  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = LOAD;
            end
            LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid && (ld_last || (ld_ptr == 8'hFF)))
                    state_nxt = RUN;
            end
            RUN: begin
                run = 1'b1;
                if (armed && halt)
                    state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start)
                    state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Loader pointer, halt arm flag and saturating run-cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_ptr      <= 8'h00;
            armed       <= 1'b0;
            cycle_count <= '0;
        end else if (start_load) begin
            ld_ptr      <= 8'h00;
            armed       <= 1'b0;
            cycle_count <= '0;
        end else begin
            if ((state == LOAD) && ld_valid)
                ld_ptr <= ld_ptr + 8'd1;
            if ((state == RUN) && !halt)
                armed <= 1'b1;
            if ((state == RUN) && !halt_seen && (cycle_count != '1))
                cycle_count <= cycle_count + 1'b1;
        end
    end

    // Single RAM write port: loader in LOAD, core in RUN
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = mem_addr;
        wr_data = mem_din;
        if (state == LOAD) begin
            wr_en   = ld_valid;
            wr_addr = ld_ptr;
            wr_data = ld_data;
        end else if (state == RUN) begin
            wr_en   = mem_we && !wp_hit;
        end
    end

    // RAM array, contents not reset
    always_ff @(posedge clk) begin
        if (wr_en)
            ram[wr_addr] <= wr_data;
    end

    // Registered read port, read-first against a same-cycle write
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mem_dout <= 8'h00;
        else
            mem_dout <= ram[mem_addr];
    end

endmodule

// File: tb/tb_simproc_mem_host.sv
// Testbench for simproc_mem_host: scoreboard of expected read data, one task
// per scenario, single summary line at the end.
module tb_simproc_mem_host;

    localparam int CYC_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       mem_addr;
    logic [7:0]       mem_din;
    logic             mem_we;
    logic [7:0]       mem_dout;
    logic             run;
    logic             halt;
    logic             start;
    logic             ld_valid;
    logic [7:0]       ld_data;
    logic             ld_last;
    logic             ld_ready;
    logic             done;
    logic [CYC_W-1:0] cycle_count;
    logic             wp_err;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] mem_model [0:255];
    logic [7:0] exp_q [$];
    logic [7:0] exp_b;

    simproc_mem_host #(.CYC_W(CYC_W), .WP_LIMIT(8'h80)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_we(mem_we), .mem_dout(mem_dout), .run(run), .halt(halt),
        .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .done(done),
        .cycle_count(cycle_count), .wp_err(wp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_one(input logic [7:0] d);
        start = 1'b1;
        tick();
        start    = 1'b0;
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = 1'b1;
        mem_model[0] = d;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; ld_valid = 0; ld_data = 0; ld_last = 0;
        halt = 0; mem_addr = 0; mem_din = 0; mem_we = 0;
        repeat (3) tick();
        checks++;
        if ({run, ld_ready, done, wp_err, mem_dout, cycle_count} !== 28'h0) begin
            failures++;
            $display("FAIL reset_outputs got run=%b rdy=%b done=%b wp=%b dout=%h cnt=%0d, want all 0",
                     run, ld_ready, done, wp_err, mem_dout, cycle_count);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_short();
        logic [7:0] bytes [3];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (ld_ready !== 1'b1) begin
            failures++; $display("FAIL load_ready got %b want 1", ld_ready);
        end
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = bytes[i]; ld_last = (i == 2);
            mem_model[i] = bytes[i];
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        checks++;
        if (ld_ready !== 1'b0 || run !== 1'b1) begin
            failures++; $display("FAIL load_exit got rdy=%b run=%b want rdy=0 run=1", ld_ready, run);
        end
        for (int i = 0; i < 3; i++) begin
            mem_addr = 8'(i);
            exp_q.push_back(mem_model[i]);
            tick();
            exp_b = exp_q.pop_front();
            checks++;
            if (mem_dout !== exp_b) begin
                failures++; $display("FAIL short_read[%0d] got %h want %h", i, mem_dout, exp_b);
            end
        end
        halt = 1'b1;
        tick();
        checks++;
        if (done !== 1'b1 || run !== 1'b0) begin
            failures++; $display("FAIL short_halt got done=%b run=%b want 1/0", done, run);
        end
    endtask

    task automatic test_load_full();
        int  n    = 0;
        bit  stop = 0;
        halt  = 1'b0;
        start = 1'b1;
        tick();
        start    = 1'b0;
        ld_valid = 1'b1;
        ld_last  = 1'b0;
        for (int c = 0; c < 300 && !stop; c++) begin
            ld_data = 8'(n) ^ 8'hA5;
            if (ld_ready === 1'b1) begin
                if (n < 256) mem_model[n] = ld_data;
                n++;
            end
            tick();
            if (ld_ready !== 1'b1) stop = 1;
        end
        ld_valid = 1'b0;
        checks++;
        if (n != 256 || !stop) begin
            failures++; $display("FAIL full_transfers got %0d want 256 (stopped=%0d)", n, stop);
        end
        checks++;
        if (run !== 1'b1) begin
            failures++; $display("FAIL full_run got %b want 1", run);
        end
        for (int k = 0; k < 3; k++) begin
            mem_addr = (k == 0) ? 8'h00 : (k == 1) ? 8'h01 : 8'hFF;
            exp_q.push_back(mem_model[mem_addr]);
            tick();
            exp_b = exp_q.pop_front();
            checks++;
            if (mem_dout !== exp_b) begin
                failures++; $display("FAIL full_read[%h] got %h want %h", mem_addr, mem_dout, exp_b);
            end
        end
        halt = 1'b1;
        tick();
    endtask

    task automatic test_run_count();
        halt = 1'b0;
        load_one(8'h77);
        repeat (10) tick();
        checks++;
        if (run !== 1'b1 || done !== 1'b0 || cycle_count !== 16'd10) begin
            failures++; $display("FAIL count_pre got run=%b done=%b cnt=%0d want 1/0/10", run, done, cycle_count);
        end
        halt = 1'b1;
        tick();
        checks++;
        if (done !== 1'b1 || run !== 1'b0 || cycle_count !== 16'd10) begin
            failures++; $display("FAIL count_halt got done=%b run=%b cnt=%0d want 1/0/10", done, run, cycle_count);
        end
        repeat (3) tick();
        checks++;
        if (cycle_count !== 16'd10 || done !== 1'b1) begin
            failures++; $display("FAIL count_hold got cnt=%0d done=%b want 10/1", cycle_count, done);
        end
    endtask

    task automatic test_stale_halt();
        halt = 1'b1;
        load_one(8'h66);
        repeat (5) tick();
        checks++;
        if (run !== 1'b1 || cycle_count !== 16'd5) begin
            failures++; $display("FAIL stale_ignored got run=%b cnt=%0d want 1/5", run, cycle_count);
        end
        halt = 1'b0;
        tick();
        halt = 1'b1;
        tick();
        checks++;
        if (done !== 1'b1 || cycle_count !== 16'd6) begin
            failures++; $display("FAIL stale_done got done=%b cnt=%0d want 1/6", done, cycle_count);
        end
    endtask

    task automatic test_rdw_wp();
        logic exp_wp;
        halt = 1'b0;
        load_one(8'h44);
        mem_addr = 8'h90; mem_din = 8'h5A; mem_we = 1'b1;
        exp_q.push_back(mem_model[8'h90]);
        mem_model[8'h90] = 8'h5A;
        tick();
        exp_b = exp_q.pop_front();
        checks++;
        if (mem_dout !== exp_b) begin
            failures++; $display("FAIL rdw_old got %h want %h", mem_dout, exp_b);
        end
        mem_we = 1'b0;
        exp_q.push_back(mem_model[8'h90]);
        tick();
        exp_b = exp_q.pop_front();
        checks++;
        if (mem_dout !== exp_b) begin
            failures++; $display("FAIL rdw_new got %h want %h", mem_dout, exp_b);
        end
        mem_addr = 8'h10; mem_din = 8'hFF; mem_we = 1'b1;
`ifdef SIMPROC_MEM_WP_EN
        exp_wp = 1'b1;
`else
        exp_wp = 1'b0;
        mem_model[8'h10] = 8'hFF;
`endif
        tick();
        mem_we = 1'b0;
        exp_q.push_back(mem_model[8'h10]);
        tick();
        exp_b = exp_q.pop_front();
        checks++;
        if (mem_dout !== exp_b || wp_err !== exp_wp) begin
            failures++; $display("FAIL wp_write got dout=%h wp=%b want %h/%b", mem_dout, wp_err, exp_b, exp_wp);
        end
        halt = 1'b1;
        tick();
        mem_addr = 8'h20; mem_din = 8'h00; mem_we = 1'b1;
        tick();
        mem_we = 1'b0;
        exp_q.push_back(mem_model[8'h20]);
        tick();
        exp_b = exp_q.pop_front();
        checks++;
        if (mem_dout !== exp_b || done !== 1'b1 || wp_err !== exp_wp) begin
            failures++; $display("FAIL done_write got dout=%h done=%b wp=%b want %h/1/%b",
                                 mem_dout, done, wp_err, exp_b, exp_wp);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (wp_err !== 1'b0 || ld_ready !== 1'b1 || done !== 1'b0 || cycle_count !== 16'd0) begin
            failures++; $display("FAIL restart got wp=%b rdy=%b done=%b cnt=%0d want 0/1/0/0",
                                 wp_err, ld_ready, done, cycle_count);
        end
    endtask

    task automatic test_reset_mid();
        ld_valid = 1'b1; ld_data = 8'hC3; ld_last = 1'b0;
        tick();
        ld_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({run, ld_ready, done, wp_err, mem_dout, cycle_count} !== 28'h0) begin
            failures++; $display("FAIL reset_mid got run=%b rdy=%b done=%b dout=%h want all 0",
                                 run, ld_ready, done, mem_dout);
        end
        start = 1'b1;
        tick();
        checks++;
        if (ld_ready !== 1'b0) begin
            failures++; $display("FAIL rst_beats_start got rdy=%b want 0", ld_ready);
        end
        rst = 1'b0; start = 1'b0;
        mem_addr = 8'h90; mem_din = 8'h00; mem_we = 1'b1;
        tick();
        mem_we = 1'b0;
        exp_q.push_back(mem_model[8'h90]);
        tick();
        exp_b = exp_q.pop_front();
        checks++;
        if (mem_dout !== exp_b || ld_ready !== 1'b0 || run !== 1'b0) begin
            failures++; $display("FAIL idle_write got dout=%h rdy=%b run=%b want %h/0/0",
                                 mem_dout, ld_ready, run, exp_b);
        end
    endtask

    initial begin
        test_reset();
        test_load_short();
        test_load_full();
        test_run_count();
        test_stale_halt();
        test_rdw_wp();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simproc_mem_host.md
Name: simproc_mem_host

Overview:
- Responder end of the simproc memory interface and host end of its run/halt debug interface.
- Owns a 256x8 synchronous RAM that serves the core's mem_addr/mem_din/mem_we requests.
- Accepts a program image over a byte-stream loader port (valid/ready), then asserts run and counts cycles until the core raises halt.
- Sits beside the core in the top level; the loader port is driven by the test/debug host.

Parameters:
- CYC_W, 16, width of the run-cycle counter.
- WP_LIMIT, 8'h80, first address NOT write-protected. Used only with SIMPROC_MEM_WP_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- mem_addr  input  8  core address.
- mem_din  input  8  core write data.
- mem_we  input  1  core write enable.
- mem_dout  output  8  read data to the core; registered.
- run  output  1  core run enable.
- halt  input  1  core halted indication.
- start  input  1  single-cycle pulse; begins a load.
- ld_valid  input  1  loader byte valid.
- ld_data  input  8  loader byte.
- ld_last  input  1  marks the final byte; qualified by ld_valid.
- ld_ready  output  1  loader may transfer.
- done  output  1  program halted; result stable.
- cycle_count  output  CYC_W  cycles spent in RUN.
- wp_err  output  1  sticky protected-write flag. Driven 0 when the feature is compiled out.

Behaviour:
- Reset (async): state=IDLE; mem_dout, run, ld_ready, done, cycle_count, wp_err, ld_ptr and the arm flag all 0. RAM contents are not reset (X until loaded).
- RAM read: every cycle, in every state, mem_dout <= RAM[mem_addr]. One-cycle latency.
- RAM read-during-write to the same address: read-first, i.e. mem_dout returns the old byte.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - ld_ready=0; core writes ignored.
  - start -> LOAD; ld_ptr=0; cycle_count=0; done=0; wp_err=0.
- LOAD:
  - ld_ready=1.
  - On ld_valid&ld_ready: RAM[ld_ptr]<=ld_data; ld_ptr++.
  - Exit to RUN when ld_last is accepted or ld_ptr==8'hFF is accepted, whichever occurs first. No wrap; the 256th byte is implicitly last.
  - Core mem_we ignored. start ignored.
  - ld_ready drops to 0 in the cycle after the last byte is accepted.
- RUN:
  - run=1; ld_ready=0; core writes honored at the clock edge.
  - cycle_count increments every RUN cycle and saturates at all-ones.
  - Arm flag sets the first cycle halt is sampled 0. halt is honored only once armed, so a stale halt from a previous program is ignored.
  - Armed and halt=1 -> DONE; run=0 and done=1 in the next cycle. cycle_count excludes the halt cycle.
  - start ignored.
- DONE:
  - done=1; run=0; cycle_count and wp_err held.
  - Core writes ignored. Reads still served, so the host can inspect memory through the mem_addr mux in the top level.
  - start -> LOAD, with the same clears as from IDLE.
- Reset mid-LOAD or mid-RUN: immediate return to IDLE with all outputs 0. Partially loaded RAM contents are retained but undefined by contract.
- Simultaneous start and rst: rst wins.

Optional Feature:
- Macro: SIMPROC_MEM_WP_EN.
- Enabled: in RUN, a core write with mem_addr < WP_LIMIT is dropped (RAM unchanged) and wp_err is set. wp_err is sticky until the next start or rst. Loader writes are never protected.
- Disabled: all RUN-state core writes are honored; wp_err is tied to 0 and no comparator logic is generated.

Test Plan:
- Reset then start; load 3 bytes 8'h11, 8'h22, 8'h33 with ld_last on the 3rd -> RAM[0..2] hold those bytes; ld_ready is 0 in the following cycle; run=1 in RUN.
- Drive ld_valid every cycle for 256 bytes with no ld_last -> exactly 256 transfers; FSM enters RUN after address 8'hFF; no wrap to address 0.
- In RUN, hold halt=0 for 10 cycles, then halt=1 -> cycle_count=10; done=1 and run=0 one cycle after halt is sampled.
- halt held at 1 from RUN entry for 5 cycles, then 0, then 1 -> DONE only after the 0 is seen; cycle_count=6.
- Core write RAM[8'h90]=8'h5A with a simultaneous read of the same address -> mem_dout shows the old value; a read next cycle shows 8'h5A.
- WP enabled, WP_LIMIT=8'h80: core writes 8'hFF to 8'h10 -> RAM unchanged, wp_err=1. A later start clears wp_err to 0.
